// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding memory requester, prefetch FIFO,
// and halfword realigner for mixed 16/32-bit instructions feeding decode.
module fetch_unit #(
  parameter logic [31:0] BOOT_ADDR  = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  localparam int RISCV_ADDR_WIDTH = 32,
  localparam int RISCV_WORD_WIDTH = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  output logic                        instr_req_o,
  output logic [RISCV_ADDR_WIDTH-1:0] instr_addr_o,
  input  logic                        instr_gnt_i,
  input  logic                        instr_rvalid_i,
  input  logic [RISCV_WORD_WIDTH-1:0] instr_rdata_i,
  input  logic                        redirect_i,
  input  logic [RISCV_ADDR_WIDTH-1:0] redirect_addr_i,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic [RISCV_WORD_WIDTH-1:0] instr_o,
  output logic [RISCV_ADDR_WIDTH-1:0] pc_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_GNT,
    WAIT_RVALID
  } state_t;

  state_t state_q, state_d;

  logic [RISCV_WORD_WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]            rd_ptr_q, wr_ptr_q;
  logic [CNT_W-1:0]            count_q;
  logic [RISCV_ADDR_WIDTH-1:0] pc_q, fetch_addr_q, req_addr_q;
  logic                        discard_q, discard_d;

  logic [RISCV_WORD_WIDTH-1:0] head;
  logic [15:0]                 next_lo;
  logic                        has_head, has_next;
  logic                        is_comp, avail;
  logic [RISCV_WORD_WIDTH-1:0] instr_raw;
  logic [RISCV_ADDR_WIDTH-1:0] pc_inc, target_word;
  logic                        fire, pop, push;

  assign head        = fifo_mem[rd_ptr_q];
  assign next_lo     = fifo_mem[rd_ptr_q + PTR_W'(1)][15:0];
  assign has_head    = (count_q != '0);
  assign has_next    = (count_q >= CNT_W'(2));
  assign target_word = {redirect_addr_i[31:2], 2'b00};

  // Aligner: pick the instruction starting at pc_q within the head word
  always_comb begin
    is_comp   = 1'b0;
    instr_raw = head;
    avail     = has_head;
    if (!pc_q[1]) begin
      is_comp   = (head[1:0] != 2'b11);
      instr_raw = is_comp ? {16'b0, head[15:0]} : head;
    end else begin
      is_comp = (head[17:16] != 2'b11);
      if (is_comp) begin
        instr_raw = {16'b0, head[31:16]};
      end else begin
        instr_raw = {next_lo, head[31:16]};
        avail     = has_head && has_next;
      end
    end
  end

  assign valid_o = avail;
  assign instr_o = avail ? instr_raw : '0;
  assign pc_o    = pc_q;

  assign fire   = avail && ready_i && !redirect_i;
  assign pc_inc = pc_q + (is_comp ? 32'd2 : 32'd4);
  // A pop happens only once the consumed instruction leaves the head word
  assign pop    = fire && (pc_inc[31:2] != pc_q[31:2]);
  assign push   = (state_q == WAIT_RVALID) && instr_rvalid_i && !discard_q && !redirect_i;

  assign instr_req_o  = (state_q == WAIT_GNT);
  assign instr_addr_o = req_addr_q;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (count_q < CNT_W'(FIFO_DEPTH)) state_d = WAIT_GNT;
      WAIT_GNT:    if (instr_gnt_i) state_d = WAIT_RVALID;
      WAIT_RVALID: if (instr_rvalid_i) state_d = IDLE;
      default:     state_d = IDLE;
    endcase
  end

  // Any redirect with a request in flight marks that response as stale
  always_comb begin
    discard_d = discard_q;
    if ((state_q == WAIT_RVALID) && instr_rvalid_i) begin
      discard_d = 1'b0;
    end else if (redirect_i && (state_q != IDLE)) begin
      discard_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      discard_q    <= 1'b0;
      pc_q         <= {BOOT_ADDR[31:1], 1'b0};
      fetch_addr_q <= {BOOT_ADDR[31:2], 2'b00};
      req_addr_q   <= {BOOT_ADDR[31:2], 2'b00};
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;

      if (redirect_i) begin
        pc_q <= {redirect_addr_i[31:1], 1'b0};
      end else if (fire) begin
        pc_q <= pc_inc;
      end

      if (redirect_i) begin
        fetch_addr_q <= target_word;
      end else if ((state_q == WAIT_GNT) && instr_gnt_i && !discard_q) begin
        fetch_addr_q <= fetch_addr_q + 32'd4;
      end

      // Address is captured once per request and held until the grant
      if ((state_q == IDLE) && (state_d == WAIT_GNT)) begin
        req_addr_q <= redirect_i ? target_word : fetch_addr_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (redirect_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= instr_rdata_i;
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: alignment, backpressure, redirect and reset cases.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        instr_req_o;
  logic [31:0] instr_addr_o;
  logic        instr_gnt_i;
  logic        instr_rvalid_i;
  logic [31:0] instr_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_addr_i;
  logic        ready_i;
  logic        valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_unit #(
    .BOOT_ADDR (32'h0000_0100),
    .FIFO_DEPTH(2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .instr_req_o    (instr_req_o),
    .instr_addr_o   (instr_addr_o),
    .instr_gnt_i    (instr_gnt_i),
    .instr_rvalid_i (instr_rvalid_i),
    .instr_rdata_i  (instr_rdata_i),
    .redirect_i     (redirect_i),
    .redirect_addr_i(redirect_addr_i),
    .ready_i        (ready_i),
    .valid_o        (valid_o),
    .instr_o        (instr_o),
    .pc_o           (pc_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20 && instr_req_o !== 1'b1; i++) @(negedge clk);
    chk({tag, "_req"}, 32'(instr_req_o), 32'd1);
  endtask

  // Grant immediately, return the word one cycle after the grant
  task automatic serve(input string tag, input logic [31:0] addr, input logic [31:0] data);
    wait_req(tag);
    chk({tag, "_addr"}, instr_addr_o, addr);
    instr_gnt_i = 1'b1;
    @(negedge clk);
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = data;
    @(negedge clk);
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
  endtask

  task automatic pulse_ready();
    ready_i = 1'b1;
    @(negedge clk);
    ready_i = 1'b0;
  endtask

  initial begin
    rst_n           = 1'b0;
    instr_gnt_i     = 1'b0;
    instr_rvalid_i  = 1'b0;
    instr_rdata_i   = '0;
    redirect_i      = 1'b0;
    redirect_addr_i = '0;
    ready_i         = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req",   32'(instr_req_o), 32'd0);
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'h0);
    chk("rst_pc",    pc_o, 32'h100);
    rst_n = 1'b1;

    // Single 32-bit word at boot address
    serve("t1", 32'h100, 32'h0000_0013);
    chk("t1_valid", 32'(valid_o), 32'd1);
    chk("t1_instr", instr_o, 32'h0000_0013);
    chk("t1_pc",    pc_o, 32'h100);
    chk("t1_idle",  32'(instr_req_o), 32'd0);
    pulse_ready();
    chk("t1_empty", 32'(valid_o), 32'd0);
    chk("t1_pcadv", pc_o, 32'h104);

    // Two compressed in one word, then a 32-bit word
    serve("t2a", 32'h104, 32'h4501_4501);
    chk("t2_c0_instr", instr_o, 32'h0000_4501);
    chk("t2_c0_pc",    pc_o, 32'h104);
    serve("t2b", 32'h108, 32'h0000_0013);
    chk("t2_c0_hold",  instr_o, 32'h0000_4501);
    ready_i = 1'b1;
    @(negedge clk);
    chk("t2_c1_instr", instr_o, 32'h0000_4501);
    chk("t2_c1_pc",    pc_o, 32'h106);
    @(negedge clk);
    chk("t2_w_instr",  instr_o, 32'h0000_0013);
    chk("t2_w_pc",     pc_o, 32'h108);
    @(negedge clk);
    ready_i = 1'b0;
    chk("t2_empty",    32'(valid_o), 32'd0);
    chk("t2_pc",       pc_o, 32'h10C);

    // 32-bit instruction straddling a word boundary
    serve("t3a", 32'h10C, 32'h0113_4501);
    chk("t3_c_instr", instr_o, 32'h0000_4501);
    chk("t3_c_pc",    pc_o, 32'h10C);
    pulse_ready();
    chk("t3_wait_valid", 32'(valid_o), 32'd0);
    chk("t3_wait_pc",    pc_o, 32'h10E);
    serve("t3b", 32'h110, 32'h0000_0000);
    chk("t3_valid", 32'(valid_o), 32'd1);
    chk("t3_instr", instr_o, 32'h0000_0113);
    chk("t3_pc",    pc_o, 32'h10E);

    // Backpressure with a full FIFO
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("t4_req_low", 32'(instr_req_o), 32'd0);
    end
    chk("t4_valid", 32'(valid_o), 32'd1);
    chk("t4_instr", instr_o, 32'h0000_0113);
    chk("t4_pc",    pc_o, 32'h10E);
    pulse_ready();
    chk("t4_next_valid", 32'(valid_o), 32'd1);
    chk("t4_next_instr", instr_o, 32'h0000_0000);
    chk("t4_next_pc",    pc_o, 32'h112);

    // Redirect while waiting for the response
    wait_req("t5");
    chk("t5_addr", instr_addr_o, 32'h114);
    instr_gnt_i = 1'b1;
    @(negedge clk);
    instr_gnt_i     = 1'b0;
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h202;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("t5_flush_valid", 32'(valid_o), 32'd0);
    chk("t5_flush_pc",    pc_o, 32'h202);
    chk("t5_flush_req",   32'(instr_req_o), 32'd0);
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    chk("t5_drop_valid", 32'(valid_o), 32'd0);
    serve("t5n", 32'h200, 32'hABCD_1234);
    chk("t5_valid", 32'(valid_o), 32'd1);
    chk("t5_instr", instr_o, 32'h0000_ABCD);
    chk("t5_pc",    pc_o, 32'h202);

    // Stalled grant, redirect during the stall, then reset mid-wait
    wait_req("t6");
    chk("t6_addr", instr_addr_o, 32'h204);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t6_hold_req",  32'(instr_req_o), 32'd1);
      chk("t6_hold_addr", instr_addr_o, 32'h204);
    end
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h300;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("t6_redir_addr",  instr_addr_o, 32'h204);
    chk("t6_redir_pc",    pc_o, 32'h300);
    chk("t6_redir_valid", 32'(valid_o), 32'd0);
    instr_gnt_i = 1'b1;
    @(negedge clk);
    instr_gnt_i    = 1'b0;
    instr_rvalid_i = 1'b1;
    instr_rdata_i  = 32'h5555_5555;
    @(negedge clk);
    instr_rvalid_i = 1'b0;
    instr_rdata_i  = '0;
    chk("t6_stale_valid", 32'(valid_o), 32'd0);
    wait_req("t6b");
    chk("t6b_addr", instr_addr_o, 32'h300);
    @(negedge clk);
    redirect_i      = 1'b1;
    redirect_addr_i = 32'h400;
    @(negedge clk);
    redirect_i = 1'b0;
    chk("t6b_hold_addr", instr_addr_o, 32'h300);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_req",   32'(instr_req_o), 32'd0);
    chk("t6_rst_valid", 32'(valid_o), 32'd0);
    chk("t6_rst_pc",    pc_o, 32'h100);
    @(negedge clk);
    rst_n = 1'b1;
    serve("t6r", 32'h100, 32'h1234_8082);
    chk("t6r_valid", 32'(valid_o), 32'd1);
    chk("t6r_instr", instr_o, 32'h0000_8082);
    chk("t6r_pc",    pc_o, 32'h100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
